// File: rtl/ext_pipe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ext_pipe_pkg : extension opcode encodings and helpers shared by ext_pipe
// Rev 1.0
// ----------------------------------------------------------------------------
package ext_pipe_pkg;

    localparam int ExtOp_WIDTH = 3;

    typedef logic [ExtOp_WIDTH-1:0] ext_op_t;

    localparam ext_op_t ExtOp_SIGNED = 3'd0;
    localparam ext_op_t ExtOp_UNSIGN = 3'd1;
    localparam ext_op_t ExtOp_HIGH16 = 3'd2;
    localparam ext_op_t ExtOp_BD14   = 3'd3;
    localparam ext_op_t ExtOp_LI24   = 3'd4;
    localparam ext_op_t ExtOp_MASK   = 3'd5;

    function automatic logic ext_op_legal(input ext_op_t op);
        return op <= ExtOp_MASK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ext_pipe_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ext_pipe_if : request/result handshake bundle between decode and ext_pipe
// Rev 1.0
// ----------------------------------------------------------------------------
interface ext_pipe_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
);
    import ext_pipe_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [25:0]       in_imm;
    ext_op_t           in_op;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    modport master (
        output in_valid, in_imm, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_imm, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );

endinterface
`default_nettype wire

// File: rtl/ext_pipe_mask_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ext_mask_gen : rlwinm-style MB/ME to 32-bit mask (IBM bit 0 = MSB)
// Rev 1.0
// ----------------------------------------------------------------------------
module ext_mask_gen (
    input  wire logic [4:0]  mb_i,
    input  wire logic [4:0]  me_i,
    output logic      [31:0] mask_o
);

    logic [31:0] w_from_mb;
    logic [31:0] w_to_me;

    // IBM bits MB..31 and 0..ME expressed as right/left shifted all-ones words
    assign w_from_mb = 32'hFFFF_FFFF >> mb_i;
    assign w_to_me   = 32'hFFFF_FFFF << (5'd31 - me_i);

    assign mask_o = (mb_i <= me_i) ? (w_from_mb & w_to_me) : (w_from_mb | w_to_me);

endmodule
`default_nettype wire

// File: rtl/ext_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ext_pipe : DEPTH-stage immediate extension unit with valid/ready and flush
// Rev 1.0
// ----------------------------------------------------------------------------
module ext_pipe
    import ext_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1,
    parameter int TAG_W  = 5
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    input  wire logic  flush,
    ext_pipe_if.slave  bus
);

    logic [DATA_W-1:0]             w_ext;
    logic                          w_illegal;
    logic [31:0]                   w_mask;
    logic                          w_accept;
    logic [DEPTH-1:0]              w_load;
    logic [DEPTH-1:0]              w_valid;
    logic [DEPTH-1:0]              w_err;
    logic [DEPTH-1:0][DATA_W-1:0]  w_data;
    logic [DEPTH-1:0][TAG_W-1:0]   w_tag;

    ext_mask_gen u_mask (
        .mb_i   (bus.in_imm[10:6]),
        .me_i   (bus.in_imm[5:1]),
        .mask_o (w_mask)
    );

    // Sign extension relies on size-casting a signed operand up to DATA_W
    always_comb begin
        w_ext     = '0;
        w_illegal = !ext_op_legal(bus.in_op);
        case (bus.in_op)
            ExtOp_SIGNED: w_ext = DATA_W'($signed(bus.in_imm[15:0]));
            ExtOp_UNSIGN: w_ext = DATA_W'(bus.in_imm[15:0]);
            ExtOp_HIGH16: w_ext = DATA_W'($signed({bus.in_imm[15:0], 16'h0000}));
            ExtOp_BD14:   w_ext = DATA_W'($signed({bus.in_imm[15:2], 2'b00}));
            ExtOp_LI24:   w_ext = DATA_W'($signed({bus.in_imm[25:2], 2'b00}));
            ExtOp_MASK:   w_ext = DATA_W'(w_mask);
            default:      w_ext = '0;
        endcase
    end

    // A stage can load if it is empty or everything downstream can advance
    always_comb begin
        w_load            = '0;
        w_load[DEPTH-1]   = !w_valid[DEPTH-1] || bus.out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            w_load[k] = !w_valid[k] || w_load[k+1];
        end
    end

    assign bus.in_ready = w_load[0] && !flush;
    assign w_accept     = bus.in_valid && bus.in_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic              in_v;
        logic              in_e;
        logic [DATA_W-1:0] in_d;
        logic [TAG_W-1:0]  in_t;
        logic              valid_q, valid_d;
        logic              err_q, err_d;
        logic [DATA_W-1:0] data_q, data_d;
        logic [TAG_W-1:0]  tag_q, tag_d;

        if (i == 0) begin : g_head
            assign in_v = w_accept;
            assign in_d = w_ext;
            assign in_t = bus.in_tag;
            assign in_e = w_illegal;
        end else begin : g_body
            assign in_v = w_valid[i-1];
            assign in_d = w_data[i-1];
            assign in_t = w_tag[i-1];
            assign in_e = w_err[i-1];
        end

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            tag_d   = tag_q;
            err_d   = err_q;
            if (flush) begin
                valid_d = 1'b0;
            end else if (w_load[i]) begin
                valid_d = in_v;
                if (in_v) begin
                    data_d = in_d;
                    tag_d  = in_t;
                    err_d  = in_e;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                tag_q   <= '0;
                err_q   <= 1'b0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
                tag_q   <= tag_d;
                err_q   <= err_d;
            end
        end

        assign w_valid[i] = valid_q;
        assign w_data[i]  = data_q;
        assign w_tag[i]   = tag_q;
        assign w_err[i]   = err_q;
    end

    assign bus.out_valid = w_valid[DEPTH-1];
    assign bus.out_data  = w_data[DEPTH-1];
    assign bus.out_tag   = w_tag[DEPTH-1];
    assign bus.out_err   = w_err[DEPTH-1];

endmodule
`default_nettype wire
